// File: rtl/axilite_csr_read_data.sv
// AXI4-Lite read responder for the CSR block: picks one word from the flat register
// vector, answers OKAY/SLVERR, and strobes the word index for clear-on-read owners.
module axilite_csr_read_data #(
   parameter int         DATA_SIZE   = 128,
   parameter int         ADDR_SIZE   = 32,
   parameter int         DATA_WIDTH  = 32,
   parameter logic [1:0] RESP_OKAY   = 2'd0,
   parameter logic [1:0] RESP_SLVERR = 2'd2,
   localparam int        NUM_WORDS   = DATA_SIZE / DATA_WIDTH,
   localparam int        IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_SIZE-1:0]  araddr,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [DATA_SIZE-1:0]  regs,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  rd_pulse,
   output logic [IDX_W-1:0]      rd_index
);
   localparam int              LSB      = $clog2(DATA_WIDTH / 8);
   localparam int              IW       = ADDR_SIZE - LSB;
   localparam logic [IW-1:0]   NUM_W_IW = IW'(NUM_WORDS);

   typedef enum logic {IDLE, RESP} state_t;
   state_t state, state_nxt;

   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] words;
   logic [IW-1:0]    idx_full;
   logic [IDX_W-1:0] idx;
   logic             in_range, ar_hs, r_hs;
   logic             unused_addr_lsb;

   assign words    = regs;
   assign idx_full = araddr[ADDR_SIZE-1:LSB];
   assign idx      = idx_full[IDX_W-1:0];
   // Compare on the full word address so high address bits can't alias into range.
   assign in_range = idx_full < NUM_W_IW;
   assign ar_hs    = arvalid && arready;
   assign r_hs     = rvalid && rready;
   assign unused_addr_lsb = ^araddr[LSB-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (ar_hs) state_nxt = RESP;
         RESP: if (r_hs)  state_nxt = IDLE;
      endcase
   end

   // Data/resp are snapshotted at the AR handshake and held through backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rdata    <= '0;
         rresp    <= 2'd0;
         rd_pulse <= 1'b0;
         rd_index <= '0;
      end else begin
         arready  <= (state_nxt == IDLE);
         rvalid   <= (state_nxt == RESP);
         rd_pulse <= ar_hs && in_range;
         if (ar_hs) begin
            rdata <= in_range ? words[idx] : '0;
            rresp <= in_range ? RESP_OKAY : RESP_SLVERR;
            if (in_range) rd_index <= idx;
         end
      end
   end
endmodule

// File: tb/tb_axilite_csr_read_data.sv
// Directed bench for axilite_csr_read_data: transaction-level model checked every
// negedge, plus literal expectations at key points of each scenario.
module tb_axilite_csr_read_data;
   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  araddr;
   logic         arvalid, arready;
   logic [127:0] regs;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid, rready, rd_pulse;
   logic [1:0]   rd_index;

   int errors = 0;
   int checks = 0;

   axilite_csr_read_data dut (
      .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .regs(regs), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .rd_pulse(rd_pulse), .rd_index(rd_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: responder is either free or holding one pending response.
   logic        m_busy = 1'b0, m_ready = 1'b0, m_pulse = 1'b0;
   logic [31:0] m_data = '0;
   logic [1:0]  m_resp = '0, m_idx = '0;
   longint unsigned m_w;
   logic [127:0] m_sh;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_ready = 0; m_pulse = 0; m_data = 0; m_resp = 0; m_idx = 0;
      end else if (!m_busy && m_ready && arvalid) begin
         m_w     = longint'(araddr) / 4;
         m_busy  = 1;
         m_ready = 0;
         m_pulse = (m_w < 4);
         if (m_w < 4) begin
            m_sh   = regs >> (m_w * 32);
            m_data = m_sh[31:0];
            m_resp = 2'd0;
            m_idx  = m_w[1:0];
         end else begin
            m_data = 32'd0;
            m_resp = 2'd2;
         end
      end else begin
         m_pulse = 0;
         if (m_busy && rready) m_busy = 0;
         m_ready = !m_busy;
      end
   end

   always @(negedge clk) begin
      chk("arready", {31'd0, arready}, {31'd0, m_ready});
      chk("rvalid", {31'd0, rvalid}, {31'd0, m_busy});
      chk("rd_pulse", {31'd0, rd_pulse}, {31'd0, m_pulse});
      chk("rd_index", {30'd0, rd_index}, {30'd0, m_idx});
      if (m_busy || rst) begin
         chk("rdata", rdata, m_data);
         chk("rresp", {30'd0, rresp}, {30'd0, m_resp});
      end
   end

   // Called at posedge+2; returns at posedge+2 with arready sampled high or timed out.
   task automatic wait_ready();
      int n = 0;
      while (arready !== 1'b1 && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      chk("ar_ready_wait", {31'd0, arready}, 32'd1);
   endtask

   // Issues a read; returns at negedge+1 with the response on R and rready high.
   task automatic start_read(input logic [31:0] a);
      araddr  = a;
      arvalid = 1'b1;
      wait_ready();
      @(posedge clk); #2;
      arvalid = 1'b0;
      rready  = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic end_read();
      @(posedge clk); #2;
      rready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; arvalid = 1'b0; rready = 1'b0; araddr = '0;
      regs = {32'h0BADF00D, 32'hDEADBEEF, 32'h12345678, 32'hA5A50000};

      @(negedge clk); #1;
      chk("rst_arready", {31'd0, arready}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rresp", {30'd0, rresp}, 32'd0);
      chk("rst_rd_pulse", {31'd0, rd_pulse}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk); #1;
      chk("arready_before_edge", {31'd0, arready}, 32'd0);
      @(posedge clk); #2;
      chk("arready_rise", {31'd0, arready}, 32'd1);

      // Basic in-range read of word 2
      rready = 1'b1;
      start_read(32'h8);
      chk("t1_rdata", rdata, 32'hDEADBEEF);
      chk("t1_rresp", {30'd0, rresp}, 32'd0);
      chk("t1_pulse", {31'd0, rd_pulse}, 32'd1);
      chk("t1_index", {30'd0, rd_index}, 32'd2);
      end_read();
      chk("t1_arready_back", {31'd0, arready}, 32'd1);
      chk("t1_pulse_clr", {31'd0, rd_pulse}, 32'd0);

      // Backpressure with arvalid held and regs changing under the held response
      araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
      wait_ready();
      @(posedge clk); #2;
      regs[63:32] = 32'h0;
      repeat (5) begin
         @(negedge clk); #1;
         chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
         chk("bp_rdata", rdata, 32'h12345678);
         chk("bp_arready", {31'd0, arready}, 32'd0);
      end
      @(posedge clk); #2;
      arvalid = 1'b0; rready = 1'b1;
      @(posedge clk); #2;
      chk("bp_done", {31'd0, rvalid}, 32'd0);
      rready = 1'b0;

      // Out-of-range reads, including a high-bit address that would alias if truncated
      start_read(32'h10);
      chk("oor_rdata", rdata, 32'd0);
      chk("oor_rresp", {30'd0, rresp}, 32'd2);
      chk("oor_pulse", {31'd0, rd_pulse}, 32'd0);
      chk("oor_index", {30'd0, rd_index}, 32'd1);
      end_read();
      start_read(32'h80000000);
      chk("oor_hi_rresp", {30'd0, rresp}, 32'd2);
      chk("oor_hi_rdata", rdata, 32'd0);
      end_read();

      // Unaligned addresses ignore the low bits
      regs[63:32] = 32'hCAFE0001;
      start_read(32'hF);
      chk("ua3_rdata", rdata, 32'h0BADF00D);
      chk("ua3_index", {30'd0, rd_index}, 32'd3);
      end_read();
      start_read(32'h6);
      chk("ua1_rdata", rdata, 32'hCAFE0001);
      chk("ua1_rresp", {30'd0, rresp}, 32'd0);
      chk("ua1_index", {30'd0, rd_index}, 32'd1);
      end_read();

      // Back-to-back at the 2-cycle minimum spacing
      araddr = 32'h0; arvalid = 1'b1; rready = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      arvalid = 1'b0; rready = 1'b0;
      @(posedge clk); #2;

      // Reset while a response is pending
      start_read(32'hC);
      chk("mr_rvalid_pre", {31'd0, rvalid}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("mr_rvalid_async", {31'd0, rvalid}, 32'd0);
      chk("mr_rdata_async", rdata, 32'd0);
      rready = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk); #1;
      chk("mr_no_pulse", {31'd0, rd_pulse}, 32'd0);
      @(posedge clk); #2;
      start_read(32'h0);
      chk("mr_rdata", rdata, 32'hA5A50000);
      chk("mr_rresp", {30'd0, rresp}, 32'd0);
      chk("mr_index", {30'd0, rd_index}, 32'd0);
      end_read();

      repeat (2) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axilite_csr_read_data.md
Name: axilite_csr_read_data

Overview:
- AXI4-Lite read-side responder for the CSR block; the counterpart of the CSR write-data path.
- Accepts read addresses on the AR channel and selects one DATA_WIDTH word from the flat register vector produced by the write path.
- Returns the word on the R channel with OKAY, or SLVERR when the address is out of range.
- Emits a one-cycle read strobe with the word index so owning logic can implement clear-on-read registers.

Parameters:
DATA_SIZE, 128, total CSR bits; must be a multiple of DATA_WIDTH
ADDR_SIZE, 32, AXI address width
DATA_WIDTH, 32, AXI data width (32 or 64)
RESP_OKAY, 0, response code for a good read
RESP_SLVERR, 2, response code for an out-of-range read

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
araddr  in  ADDR_SIZE  byte read address
arvalid  in  1  read address valid
arready  out  1  read address ready
regs  in  DATA_SIZE  flat CSR contents; word k = regs[k*DATA_WIDTH +: DATA_WIDTH]
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
rd_pulse  out  1  one-cycle strobe for an accepted in-range read
rd_index  out  IDX_W  word index of the current or last read; IDX_W = max(1, clog2(DATA_SIZE/DATA_WIDTH))

Behaviour:
- Derived constants:
  - NUM_WORDS = DATA_SIZE/DATA_WIDTH
  - LSB = clog2(DATA_WIDTH/8)
  - index = araddr >> LSB; low LSB address bits are ignored (no alignment error)
  - in_range = index < NUM_WORDS, computed on the full ADDR_SIZE-LSB bits; upper bits are not truncated before the compare
- Reset: all outputs are registered and clear asynchronously on rst=1:
  - arready=0, rvalid=0, rdata=0, rresp=0, rd_pulse=0, rd_index=0
  - FSM forced to IDLE
- State machine (two states):
  - IDLE: arready=1, rvalid=0.
  - IDLE -> RESP on arvalid&&arready at a clock edge. At that edge:
    - rdata <= in_range ? word[index] : 0
    - rresp <= in_range ? RESP_OKAY : RESP_SLVERR
    - rd_index <= index when in_range (unchanged otherwise)
    - rd_pulse <= in_range
    - arready <= 0, rvalid <= 1
  - RESP: rvalid=1, arready=0.
    - rdata and rresp are held stable regardless of later regs changes (snapshot is taken at the AR handshake edge).
    - rd_pulse clears after exactly one cycle.
  - RESP -> IDLE on rvalid&&rready: rvalid <= 0, arready <= 1.
- Arready timing:
  - arready first rises on the first clk edge after rst deasserts.
  - AR is never accepted in the same cycle as the R handshake.
  - Minimum spacing is 2 cycles per transaction: AR accepted at edge N, rvalid high from N, R handshake at edge N+1 when rready=1, next AR accepted at edge N+2.
- Latency: rvalid asserts on the same edge that accepts AR, so data is visible the cycle after arvalid is sampled.
- rready asserted while rvalid=0 has no effect.
- arvalid in RESP is ignored, not queued; the master must hold it per AXI rules.
- Reset mid-transaction: rvalid drops immediately (async). The pending response is discarded and no rd_pulse is issued afterwards.

Test Plan:
- Reset release -> arready=0 during rst, arready=1 one edge after release; rvalid=0, rdata=0, rresp=0, rd_pulse=0.
- regs word2=0xDEADBEEF, araddr=0x8 arvalid=1, rready=1 -> rvalid next cycle:
  - rdata=0xDEADBEEF, rresp=0, rd_pulse=1 for one cycle, rd_index=2
  - arready back to 1 one edge later
- Backpressure: araddr=0x4 with word1=0x12345678, rready=0 for 5 cycles while regs word1 changes to 0 and arvalid stays high -> rvalid held 5 cycles, rdata stays 0x12345678, arready=0, no second accept; rready=1 completes the read.
- Out of range: araddr=0x10 (NUM_WORDS=4) -> rdata=0, rresp=2, rd_pulse=0, rd_index unchanged. Repeat with araddr=0x80000000 -> also rresp=2.
- Unaligned: araddr=0x6 -> word1 returned, rresp=0, rd_index=1.
- Reset mid-RESP: rst asserted while rvalid=1 -> rvalid=0 asynchronously; after release, a fresh read of 0x0 returns word0 with OKAY.
